// File: rtl/pll_recfg_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_recfg_ctrl_if -- divider-set request/acknowledge bus for pll_recfg_ctrl. Rev 1.0 |
// +--------------------------------------------------------------------------+
interface pll_recfg_ctrl_if;
  logic        cfg_req;
  logic [9:0]  cfg_idiv;
  logic [9:0]  cfg_fdiv;
  logic [9:0]  cfg_odiv0;
  logic [9:0]  cfg_duty0;
  logic [12:0] cfg_phase0;
  logic        cfg_ack;
  logic        cfg_err;

  modport master (
    output cfg_req, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_duty0, cfg_phase0,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_req, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_duty0, cfg_phase0,
    output cfg_ack, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/pll_recfg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_recfg_ctrl -- PLL power-up/reset/lock sequencer with dynamic reconfig. |
// | Option macro: PLL_RECFG_AUTO_RECOVER_EN.                       Rev 1.0 |
// +--------------------------------------------------------------------------+
module pll_recfg_ctrl #(
  parameter int          PWD_CYCLES   = 10,
  parameter int          RST_CYCLES   = 10,
  parameter int          LOCK_FILTER  = 3,
  parameter int          LOCK_TIMEOUT = 65535,
  parameter int          MAX_RETRY    = 3,
  parameter logic [9:0]  DEF_IDIV     = 10'd2,
  parameter logic [9:0]  DEF_FDIV     = 10'd32,
  parameter logic [9:0]  DEF_ODIV0    = 10'd100,
  parameter logic [9:0]  DEF_DUTY0    = 10'd100,
  parameter logic [12:0] DEF_PHASE0   = 13'd16
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             pll_lock_i,
  pll_recfg_ctrl_if.slave  cfg_if,
  output logic             pll_pwd_o,
  output logic             pll_rst_o,
  output logic             rstodiv_o,
  output logic [9:0]       dyn_idiv_o,
  output logic [9:0]       dyn_fdiv_o,
  output logic [9:0]       dyn_odiv0_o,
  output logic [9:0]       dyn_duty0_o,
  output logic [12:0]      dyn_phase0_o,
  output logic             clkout0_gate_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [2:0]       lock_loss_cnt_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PWD   = 3'd1,
    S_RST   = 3'd2,
    S_WAIT  = 3'd3,
    S_RUN   = 3'd4,
    S_RECFG = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  localparam logic [7:0]  c_pwd_last  = 8'(PWD_CYCLES - 1);
  localparam logic [7:0]  c_rst_last  = 8'(RST_CYCLES - 1);
  localparam logic [3:0]  c_filt_last = 4'(LOCK_FILTER - 1);
  localparam logic [15:0] c_tmo_last  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  c_max_retry = 8'(MAX_RETRY);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] tmo_q;
  logic [3:0]  filt_q;
  logic [7:0]  retry_q;
  logic [1:0]  sync_q;
  logic        pll_pwd_q, pll_rst_q, rstodiv_q;
  logic [9:0]  dyn_idiv_q, dyn_fdiv_q, dyn_odiv0_q, dyn_duty0_q;
  logic [12:0] dyn_phase0_q;
  logic        gate_q, ready_q, fail_q, cfg_ack_q, cfg_err_q;
  logic [2:0]  lock_loss_q;

  logic        w_lock_s;
  logic        w_cfg_ok;
  logic [7:0]  retry_d;

  assign w_lock_s = sync_q[1];
  assign w_cfg_ok = (cfg_if.cfg_idiv != 10'd0) && (cfg_if.cfg_fdiv != 10'd0) &&
                    (cfg_if.cfg_odiv0 != 10'd0);
  assign retry_d  = retry_q + 8'd1;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      tmo_q        <= 16'd0;
      filt_q       <= 4'd0;
      retry_q      <= 8'd0;
      sync_q       <= 2'b00;
      pll_pwd_q    <= 1'b0;
      pll_rst_q    <= 1'b0;
      rstodiv_q    <= 1'b0;
      dyn_idiv_q   <= DEF_IDIV;
      dyn_fdiv_q   <= DEF_FDIV;
      dyn_odiv0_q  <= DEF_ODIV0;
      dyn_duty0_q  <= DEF_DUTY0;
      dyn_phase0_q <= DEF_PHASE0;
      gate_q       <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      lock_loss_q  <= 3'd0;
    end else begin
      sync_q    <= {sync_q[0], pll_lock_i};
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_PWD;
            pll_pwd_q <= 1'b1;
            cnt_q     <= 8'd0;
          end
        end
        S_PWD: begin
          if (cnt_q == c_pwd_last) begin
            state_q   <= S_RST;
            pll_pwd_q <= 1'b0;
            pll_rst_q <= 1'b1;
            cnt_q     <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RST: begin
          if (cnt_q == c_rst_last) begin
            state_q   <= S_WAIT;
            pll_rst_q <= 1'b0;
            tmo_q     <= 16'd0;
            filt_q    <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RECFG: begin
          if (cnt_q == c_rst_last) begin
            state_q   <= S_WAIT;
            rstodiv_q <= 1'b0;
            tmo_q     <= 16'd0;
            filt_q    <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 16'd1;
          if (w_lock_s && (filt_q == c_filt_last)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
            gate_q  <= 1'b0;
            retry_q <= 8'd0;
          end else if (tmo_q == c_tmo_last) begin
            retry_q <= retry_d;
            if (retry_d < c_max_retry) begin
              state_q   <= S_PWD;
              pll_pwd_q <= 1'b1;
              cnt_q     <= 8'd0;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end else begin
            filt_q <= w_lock_s ? filt_q + 4'd1 : 4'd0;
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            if (lock_loss_q != 3'd7) lock_loss_q <= lock_loss_q + 3'd1;
            ready_q <= 1'b0;
            gate_q  <= 1'b1;
`ifdef PLL_RECFG_AUTO_RECOVER_EN
            state_q   <= S_RST;
            pll_rst_q <= 1'b1;
            cnt_q     <= 8'd0;
`else
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
`endif
          end else if (cfg_if.cfg_req && !cfg_ack_q) begin
            // A master still holding req in the cycle after a reject must not earn a second ack.
            cfg_ack_q <= 1'b1;
            if (w_cfg_ok) begin
              dyn_idiv_q   <= cfg_if.cfg_idiv;
              dyn_fdiv_q   <= cfg_if.cfg_fdiv;
              dyn_odiv0_q  <= cfg_if.cfg_odiv0;
              dyn_duty0_q  <= cfg_if.cfg_duty0;
              dyn_phase0_q <= cfg_if.cfg_phase0;
              state_q      <= S_RECFG;
              rstodiv_q    <= 1'b1;
              cnt_q        <= 8'd0;
              ready_q      <= 1'b0;
              gate_q       <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_FAIL: begin
          if (start_i) begin
            state_q   <= S_PWD;
            retry_q   <= 8'd0;
            pll_pwd_q <= 1'b1;
            fail_q    <= 1'b0;
            cnt_q     <= 8'd0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pll_pwd_o       = pll_pwd_q;
  assign pll_rst_o       = pll_rst_q;
  assign rstodiv_o       = rstodiv_q;
  assign dyn_idiv_o      = dyn_idiv_q;
  assign dyn_fdiv_o      = dyn_fdiv_q;
  assign dyn_odiv0_o     = dyn_odiv0_q;
  assign dyn_duty0_o     = dyn_duty0_q;
  assign dyn_phase0_o    = dyn_phase0_q;
  assign clkout0_gate_o  = gate_q;
  assign ready_o         = ready_q;
  assign fail_o          = fail_q;
  assign lock_loss_cnt_o = lock_loss_q;
  assign state_o         = state_q;
  assign cfg_if.cfg_ack  = cfg_ack_q;
  assign cfg_if.cfg_err  = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_recfg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pll_recfg_ctrl -- directed self-checking bench for pll_recfg_ctrl.      |
// | Expectations follow PLL_RECFG_AUTO_RECOVER_EN when defined.    Rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_pll_recfg_ctrl;

  logic        clk_tb = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        pll_lock_i;
  logic        pll_pwd_o, pll_rst_o, rstodiv_o;
  logic [9:0]  dyn_idiv_o, dyn_fdiv_o, dyn_odiv0_o, dyn_duty0_o;
  logic [12:0] dyn_phase0_o;
  logic        clkout0_gate_o, ready_o, fail_o;
  logic [2:0]  lock_loss_cnt_o, state_o;

  int n_vec = 0;
  int n_err = 0;

  pll_recfg_ctrl_if bus ();

  pll_recfg_ctrl #(.LOCK_TIMEOUT(100)) dut (
    .clk_tb          (clk_tb),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .pll_lock_i      (pll_lock_i),
    .cfg_if          (bus),
    .pll_pwd_o       (pll_pwd_o),
    .pll_rst_o       (pll_rst_o),
    .rstodiv_o       (rstodiv_o),
    .dyn_idiv_o      (dyn_idiv_o),
    .dyn_fdiv_o      (dyn_fdiv_o),
    .dyn_odiv0_o     (dyn_odiv0_o),
    .dyn_duty0_o     (dyn_duty0_o),
    .dyn_phase0_o    (dyn_phase0_o),
    .clkout0_gate_o  (clkout0_gate_o),
    .ready_o         (ready_o),
    .fail_o          (fail_o),
    .lock_loss_cnt_o (lock_loss_cnt_o),
    .state_o         (state_o)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic set_cfg(input int idiv, input int fdiv, input int odiv, input int duty);
    bus.cfg_idiv   = 10'(idiv);
    bus.cfg_fdiv   = 10'(fdiv);
    bus.cfg_odiv0  = 10'(odiv);
    bus.cfg_duty0  = 10'(duty);
    bus.cfg_phase0 = 13'd5;
    bus.cfg_req    = 1'b1;
  endtask

  initial begin
    int n;
    int pwd_rises, rst_rises;
    logic pwd_prev, rst_prev;

    rst_n = 1'b0; start_i = 1'b0; pll_lock_i = 1'b0;
    bus.cfg_req = 1'b0; bus.cfg_idiv = '0; bus.cfg_fdiv = '0;
    bus.cfg_odiv0 = '0; bus.cfg_duty0 = '0; bus.cfg_phase0 = '0;
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_pwd", 32'(pll_pwd_o), 0);
    chk("rst_gate", 32'(clkout0_gate_o), 1);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_odiv0", 32'(dyn_odiv0_o), 100);
    chk("rst_phase0", 32'(dyn_phase0_o), 16);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_hold", 32'(state_o), 0);

    // Bring-up: PWD and RST lengths, lock 50 cycles into WAIT_LOCK
    pulse_start();
    chk("pwd_enter", 32'(state_o), 1);
    n = 0;
    while (pll_pwd_o && n < 300) begin n++; tick(); end
    chk("pwd_len", n, 10);
    chk("rst_after_pwd", 32'(pll_rst_o), 1);
    n = 0;
    while (pll_rst_o && n < 300) begin n++; tick(); end
    chk("rst_len", n, 10);
    chk("wait_enter", 32'(state_o), 3);
    repeat (49) tick();
    pll_lock_i = 1'b1;
    n = 0;
    while (!ready_o && n < 50) begin tick(); n++; end
    chk("lock_latency", n, 5);
    chk("run_gate", 32'(clkout0_gate_o), 0);
    chk("run_state", 32'(state_o), 4);

    // Rejected request: zero output divider
    set_cfg(2, 32, 0, 50);
    tick();
    chk("bad_ack", 32'(bus.cfg_ack), 1);
    chk("bad_err", 32'(bus.cfg_err), 1);
    chk("bad_odiv0", 32'(dyn_odiv0_o), 100);
    chk("bad_ready", 32'(ready_o), 1);
    bus.cfg_req = 1'b0;
    tick();
    chk("bad_ack_pulse", 32'(bus.cfg_ack), 0);
    chk("bad_state", 32'(state_o), 4);

    // Accepted request
    set_cfg(2, 32, 200, 200);
    tick();
    chk("good_ack", 32'(bus.cfg_ack), 1);
    chk("good_err", 32'(bus.cfg_err), 0);
    chk("good_odiv0", 32'(dyn_odiv0_o), 200);
    chk("good_duty0", 32'(dyn_duty0_o), 200);
    chk("recfg_state", 32'(state_o), 5);
    chk("recfg_ready", 32'(ready_o), 0);
    bus.cfg_req = 1'b0;
    n = 0;
    while (rstodiv_o && n < 300) begin n++; tick(); end
    chk("rstodiv_len", n, 10);
    chk("good_ack_pulse", 32'(bus.cfg_ack), 0);
    chk("relock_wait_ready", 32'(ready_o), 0);
    n = 0;
    while (!ready_o && n < 200) begin tick(); n++; end
    chk("relock", 32'(ready_o), 1);

    // Reset in the middle of RECFG
    set_cfg(3, 40, 150, 60);
    tick();
    bus.cfg_req = 1'b0;
    chk("recfg2_state", 32'(state_o), 5);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 0);
    chk("arst_rstodiv", 32'(rstodiv_o), 0);
    chk("arst_odiv0", 32'(dyn_odiv0_o), 100);
    chk("arst_gate", 32'(clkout0_gate_o), 1);
    chk("arst_ready", 32'(ready_o), 0);
    #2;
    rst_n = 1'b1;

    // Lock loss coinciding with a new request
    pulse_start();
    n = 0;
    while (!ready_o && n < 400) begin tick(); n++; end
    chk("bringup2", 32'(ready_o), 1);
    pll_lock_i = 1'b0;
    repeat (2) tick();
    set_cfg(2, 32, 120, 80);
    tick();
    chk("loss_no_ack", 32'(bus.cfg_ack), 0);
    chk("loss_cnt", 32'(lock_loss_cnt_o), 1);
    chk("loss_ready", 32'(ready_o), 0);
`ifdef PLL_RECFG_AUTO_RECOVER_EN
    chk("loss_state", 32'(state_o), 2);
    chk("loss_pll_rst", 32'(pll_rst_o), 1);
    pll_lock_i = 1'b1;
    n = 0;
    while (!bus.cfg_ack && n < 100) begin tick(); n++; end
    chk("pending_ack", 32'(bus.cfg_ack), 1);
    chk("pending_odiv0", 32'(dyn_odiv0_o), 120);
    chk("pending_state", 32'(state_o), 5);
`else
    chk("loss_state", 32'(state_o), 6);
    chk("loss_fail", 32'(fail_o), 1);
    repeat (3) tick();
    chk("fail_pending_ack", 32'(bus.cfg_ack), 0);
    chk("fail_odiv0", 32'(dyn_odiv0_o), 100);
`endif
    bus.cfg_req = 1'b0;

    // Lock timeout: three attempts then FAIL
    rst_n = 1'b0;
    pll_lock_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    pwd_rises = 1; rst_rises = 0;
    pwd_prev = pll_pwd_o; rst_prev = pll_rst_o;
    n = 0;
    while (!fail_o && n < 2000) begin
      tick(); n++;
      if (pll_pwd_o && !pwd_prev) pwd_rises++;
      if (pll_rst_o && !rst_prev) rst_rises++;
      pwd_prev = pll_pwd_o; rst_prev = pll_rst_o;
    end
    chk("tmo_fail", 32'(fail_o), 1);
    chk("tmo_state", 32'(state_o), 6);
    chk("tmo_pwd_attempts", pwd_rises, 3);
    chk("tmo_rst_attempts", rst_rises, 3);
    chk("tmo_cycles", n, 360);
    pulse_start();
    chk("fail_restart", 32'(state_o), 1);
    chk("fail_clear", 32'(fail_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
